ara_tohost_monitor: RTL and testbench
=====================================

// Module: ara_tohost_monitor
// PURPOSE
// Passive end-of-computation monitor inside ara_testharness. It snoops the AXI write channels
// between the Ara system and L2 memory and detects writes to the tohost word. It then drives
// the 64-bit exit_o consumed by the Verilator/RTL testbench top.
// A cycle watchdog forces a failing exit if the program never finishes.
// PARAMETERS
// AxiAddrWidth   64            AXI address width
// AxiDataWidth   64            AXI data width, a power of two and >=64
// TohostAddr     'h8000_1000   byte address of the 64-bit tohost word, 8-byte aligned
// AwFifoDepth    4             outstanding AW entries awaiting W data, power of two
// TimeoutCycles  0             watchdog limit in cycles; 0 = watchdog disabled
// TimeoutCode    'hDEAD        exit code reported on watchdog expiry
// OverflowCode   'hBEEF        exit code reported on AW FIFO overflow
// PORTS
// clk_i         in   1                 clock
// rst_ni        in   1                 asynchronous reset, active low
// aw_valid_i    in   1                 snooped AW valid
// aw_ready_i    in   1                 snooped AW ready
// aw_addr_i     in   AxiAddrWidth      snooped AW address
// w_valid_i     in   1                 snooped W valid
// w_ready_i     in   1                 snooped W ready
// w_data_i      in   AxiDataWidth      snooped W data
// w_strb_i      in   AxiDataWidth/8    snooped W strobes
// w_last_i      in   1                 snooped W last beat
// exit_o        out  64                {code[62:0], done}; bit0=1 means the test has ended
// overflow_o    out  1                 sticky AW-FIFO overflow flag
// BEHAVIOUR
// - Reset (async, rst_ni=0): exit_o=0, overflow_o=0, tohost shadow=0, FIFO empty,
//   watchdog=0, beat-first flag=1. All state clears immediately, including mid-burst.
// - Handshakes: AW fires on aw_valid_i&aw_ready_i; W fires on w_valid_i&w_ready_i.
//   The monitor never drives ready signals and is purely observational.
// - AW fire: push {match, lane} into the FIFO.
//   match = (aw_addr_i & ~(AxiDataWidth/8-1)) == (TohostAddr & ~(AxiDataWidth/8-1)).
//   lane = TohostAddr[$clog2(AxiDataWidth/8)-1:3], a constant.
// - AW fire with the FIFO full and no same-cycle pop: set overflow_o (sticky). Set exit_o to
//   {OverflowCode,1} on the next edge if exit_o[0]==0. The entry is dropped.
// - W fire: the head entry applies. A same-cycle AW fire with an empty FIFO applies directly
//   (bypass) and is never pushed. Only the first beat of a burst is checked; a beat-first
//   flag is cleared on a non-last beat and set on a w_last_i beat. The FIFO pops on a
//   w_last_i fire.
// - W fire with an empty FIFO and no same-cycle AW: the beat is ignored and no state changes.
// - Matched first beat: for each byte b in 0..7 with w_strb_i[lane*8+b]=1, the shadow byte b
//   takes w_data_i[lane*64+8b +: 8]. The merged value is new = (shadow with strobed bytes).
//   If new[0]==1 and exit_o[0]==0, then exit_o <= new on the same edge (1-cycle latency).
//   If new[0]==0, only the shadow updates (syscall-style writes are ignored).
// - Sticky: once exit_o[0]=1, exit_o never changes until reset. A later overflow still sets
//   overflow_o but does not alter exit_o.
// - Watchdog: when TimeoutCycles!=0, a counter increments every cycle while exit_o[0]==0.
//   When it reaches TimeoutCycles-1, exit_o <= {TimeoutCode,1} on the next edge.
//   Counter width is $clog2(TimeoutCycles+1) and it saturates without wrapping.
// - Priority in one cycle: W tohost exit > overflow exit > watchdog exit.
// - FIFO pointers wrap modulo AwFifoDepth. A simultaneous push and pop when full is legal:
//   no overflow, count unchanged.
// TESTING
// 1. Single beat: AW@TohostAddr, W data=1, strobe all ones -> exit_o=1 one cycle after W fire.
// 2. W before AW: W data=0x55 (code 42, done) then AW two cycles later -> exit_o=0x55 only
//    after AW fires (bypass path); no earlier change.
// 3. Partial strobes: write byte0=0x00 with data=0x0 then byte1=0x01 -> no exit.
//    Then byte0=0x03 -> exit_o=0x0103.
// 4. Non-matching traffic: 4-beat burst to TohostAddr+0x1000 with data bit0=1 -> exit_o stays
//    0 and FIFO empty afterwards.
// 5. Overflow: 5 AWs with no W (depth 4) -> overflow_o=1, exit_o={OverflowCode,1}; later
//    tohost write -> exit_o unchanged.
// 6. Watchdog: TimeoutCycles=100, no traffic -> exit_o={TimeoutCode,1} at cycle 100.
//    Reset asserted mid-run -> all outputs 0 immediately, counter restarts.

Source files
------------

// File: rtl/ara_tohost_monitor.sv
// Passive tohost snooper: watches AXI AW/W handshakes towards L2 and reports the program exit code.
// Also flags AW FIFO overflow and fires a watchdog exit if the program never terminates.
module ara_tohost_monitor #(
    parameter int unsigned                AxiAddrWidth  = 64,
    parameter int unsigned                AxiDataWidth  = 64,
    parameter logic [AxiAddrWidth-1:0]    TohostAddr    = 'h8000_1000,
    parameter int unsigned                AwFifoDepth   = 4,
    parameter int unsigned                TimeoutCycles = 0,
    parameter logic [63:0]                TimeoutCode   = 'hDEAD,
    parameter logic [63:0]                OverflowCode  = 'hBEEF
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      aw_valid_i,
    input  logic                      aw_ready_i,
    input  logic [AxiAddrWidth-1:0]   aw_addr_i,
    input  logic                      w_valid_i,
    input  logic                      w_ready_i,
    input  logic [AxiDataWidth-1:0]   w_data_i,
    input  logic [AxiDataWidth/8-1:0] w_strb_i,
    input  logic                      w_last_i,
    output logic [63:0]               exit_o,
    output logic                      overflow_o
);

    localparam int unsigned StrbW    = AxiDataWidth / 8;
    localparam int unsigned NumLanes = AxiDataWidth / 64;
    localparam logic [AxiAddrWidth-1:0] LaneAddr = (TohostAddr >> 3) % AxiAddrWidth'(NumLanes);
    localparam int unsigned Lane     = int'(LaneAddr);
    localparam logic [AxiAddrWidth-1:0] AddrMask = ~AxiAddrWidth'(StrbW - 1);
    localparam logic [AxiAddrWidth-1:0] TohostWord = TohostAddr & AddrMask;

    localparam int unsigned PtrW  = (AwFifoDepth > 1) ? $clog2(AwFifoDepth) : 1;
    localparam int unsigned WdW   = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam int unsigned WdLast = (TimeoutCycles == 0) ? 0 : TimeoutCycles - 1;
    localparam logic [WdW-1:0] WdLastV = WdW'(WdLast);
    localparam logic [WdW-1:0] WdMaxV  = WdW'(TimeoutCycles);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(AwFifoDepth - 1);
    localparam logic [PtrW:0]   CntFull = (PtrW + 1)'(AwFifoDepth);

    // Lane is a compile-time constant, so each FIFO entry only needs its match bit.
    logic [AwFifoDepth-1:0] fifo_q, fifo_d;
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PtrW:0]          count_q, count_d;
    logic [63:0]            shadow_q, shadow_d;
    logic [63:0]            exit_q, exit_d;
    logic                   overflow_q, overflow_d;
    logic                   beat_first_q, beat_first_d;
    logic [WdW-1:0]         wd_q, wd_d;

    logic        aw_fire, w_fire, aw_match;
    logic        fifo_empty, fifo_full;
    logic        bypass, w_active, head_match;
    logic        push, pop, overflow_evt;
    logic        tohost_write, wd_expire, done;
    logic [63:0] lane_data, merged;
    logic [7:0]  lane_strb;

    assign aw_fire    = aw_valid_i & aw_ready_i;
    assign w_fire     = w_valid_i & w_ready_i;
    assign aw_match   = (aw_addr_i & AddrMask) == TohostWord;
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CntFull);
    assign bypass     = aw_fire & w_fire & fifo_empty;
    assign w_active   = w_fire & (~fifo_empty | aw_fire);
    assign head_match = bypass ? aw_match : fifo_q[rd_ptr_q];
    assign pop        = w_fire & w_last_i & ~fifo_empty;
    assign push       = aw_fire & ~bypass & (~fifo_full | pop);
    assign overflow_evt = aw_fire & fifo_full & ~pop;
    assign done       = exit_q[0];

    assign lane_data  = w_data_i[Lane*64 +: 64];
    assign lane_strb  = w_strb_i[Lane*8 +: 8];
    assign tohost_write = w_active & beat_first_q & head_match;
    assign wd_expire  = (TimeoutCycles != 0) & ~done & (wd_q == WdLastV);

    always_comb begin
        merged = shadow_q;
        for (int b = 0; b < 8; b++) begin
            if (lane_strb[b]) merged[8*b +: 8] = lane_data[8*b +: 8];
        end
    end

    always_comb begin
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            fifo_d[wr_ptr_q] = aw_match;
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        shadow_d     = shadow_q;
        beat_first_d = beat_first_q;
        overflow_d   = overflow_q | overflow_evt;
        exit_d       = exit_q;
        wd_d         = wd_q;
        if (w_active) begin
            beat_first_d = w_last_i;
        end
        if (tohost_write) begin
            shadow_d = merged;
        end
        // Exit sources in priority order; the first done value is sticky until reset.
        if (!done) begin
            if (tohost_write && merged[0]) begin
                exit_d = merged;
            end else if (overflow_evt) begin
                exit_d = {OverflowCode[62:0], 1'b1};
            end else if (wd_expire) begin
                exit_d = {TimeoutCode[62:0], 1'b1};
            end
            if (wd_q != WdMaxV) begin
                wd_d = wd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_q       <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            shadow_q     <= '0;
            exit_q       <= '0;
            overflow_q   <= 1'b0;
            beat_first_q <= 1'b1;
            wd_q         <= '0;
        end else begin
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            shadow_q     <= shadow_d;
            exit_q       <= exit_d;
            overflow_q   <= overflow_d;
            beat_first_q <= beat_first_d;
            wd_q         <= wd_d;
        end
    end

    assign exit_o     = exit_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_ara_tohost_monitor.sv
// Directed bench for ara_tohost_monitor: one instance without watchdog, one with a 100-cycle watchdog.
// Both share stimulus; each task checks its own expected values inline.
module tb_ara_tohost_monitor;

    localparam logic [63:0] TOHOST  = 64'h8000_1000;
    localparam logic [63:0] OTHER   = 64'h8000_2000;
    localparam logic [63:0] OVF_EXIT = 64'h1_7DDF;
    localparam logic [63:0] TO_EXIT  = 64'h1_BD5B;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        aw_valid = 1'b0, aw_ready = 1'b0;
    logic [63:0] aw_addr = '0;
    logic        w_valid = 1'b0, w_ready = 1'b0;
    logic [63:0] w_data = '0;
    logic [7:0]  w_strb = '0;
    logic        w_last = 1'b0;
    logic [63:0] exit_a, exit_w;
    logic        ovf_a, ovf_w;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ara_tohost_monitor #(.TimeoutCycles(0)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .aw_valid_i(aw_valid), .aw_ready_i(aw_ready), .aw_addr_i(aw_addr),
        .w_valid_i(w_valid), .w_ready_i(w_ready), .w_data_i(w_data),
        .w_strb_i(w_strb), .w_last_i(w_last),
        .exit_o(exit_a), .overflow_o(ovf_a)
    );

    ara_tohost_monitor #(.TimeoutCycles(100)) dut_wd (
        .clk_i(clk), .rst_ni(rst_n),
        .aw_valid_i(aw_valid), .aw_ready_i(aw_ready), .aw_addr_i(aw_addr),
        .w_valid_i(w_valid), .w_ready_i(w_ready), .w_data_i(w_data),
        .w_strb_i(w_strb), .w_last_i(w_last),
        .exit_o(exit_w), .overflow_o(ovf_w)
    );

    task automatic do_reset();
        aw_valid = 0; aw_ready = 0; w_valid = 0; w_ready = 0; w_last = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic beat(input logic aw, input logic [63:0] addr, input logic w,
                        input logic [63:0] data, input logic [7:0] strb, input logic last);
        aw_valid = aw; aw_ready = aw; aw_addr = addr;
        w_valid = w; w_ready = w; w_data = data; w_strb = strb; w_last = last;
        @(posedge clk); #1;
        aw_valid = 0; aw_ready = 0; w_valid = 0; w_ready = 0; w_last = 0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (exit_a !== 64'h0) begin $display("FAIL reset_exit actual=%h expected=%h", exit_a, 64'h0); bad++; end
        total++;
        if (ovf_a !== 1'b0) begin $display("FAIL reset_ovf actual=%b expected=0", ovf_a); bad++; end
    endtask

    task automatic test_single_beat();
        do_reset();
        beat(1, TOHOST, 0, 0, 0, 0);
        total++;
        if (exit_a !== 64'h0) begin $display("FAIL single_pre actual=%h expected=0", exit_a); bad++; end
        beat(0, 0, 1, 64'h1, 8'hFF, 1);
        total++;
        if (exit_a !== 64'h1) begin $display("FAIL single_exit actual=%h expected=1", exit_a); bad++; end
    endtask

    task automatic test_w_before_aw();
        do_reset();
        beat(0, 0, 1, 64'h55, 8'hFF, 1);
        total++;
        if (exit_a !== 64'h0) begin $display("FAIL wfirst_ignored actual=%h expected=0", exit_a); bad++; end
        beat(0, 0, 0, 0, 0, 0);
        total++;
        if (exit_a !== 64'h0) begin $display("FAIL wfirst_idle actual=%h expected=0", exit_a); bad++; end
        beat(1, TOHOST, 1, 64'h55, 8'hFF, 1);
        total++;
        if (exit_a !== 64'h55) begin $display("FAIL wfirst_bypass actual=%h expected=55", exit_a); bad++; end
    endtask

    task automatic test_partial_strobes();
        do_reset();
        beat(1, TOHOST, 1, 64'h0, 8'h01, 1);
        total++;
        if (exit_a !== 64'h0) begin $display("FAIL strb_byte0 actual=%h expected=0", exit_a); bad++; end
        beat(1, TOHOST, 1, 64'h0100, 8'h02, 1);
        total++;
        if (exit_a !== 64'h0) begin $display("FAIL strb_byte1 actual=%h expected=0", exit_a); bad++; end
        beat(1, TOHOST, 1, 64'h03, 8'h01, 1);
        total++;
        if (exit_a !== 64'h0103) begin $display("FAIL strb_merge actual=%h expected=103", exit_a); bad++; end
    endtask

    task automatic test_burst_first_only();
        do_reset();
        beat(1, TOHOST, 0, 0, 0, 0);
        beat(0, 0, 1, 64'h10, 8'hFF, 0);
        beat(0, 0, 1, 64'h1, 8'hFF, 0);
        beat(0, 0, 1, 64'h1, 8'hFF, 1);
        total++;
        if (exit_a !== 64'h0) begin $display("FAIL burst_later_beats actual=%h expected=0", exit_a); bad++; end
        beat(1, TOHOST, 1, 64'h21, 8'h01, 1);
        total++;
        if (exit_a !== 64'h21) begin $display("FAIL burst_shadow actual=%h expected=21", exit_a); bad++; end
    endtask

    task automatic test_nonmatching();
        do_reset();
        beat(1, OTHER, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) beat(0, 0, 1, 64'h1, 8'hFF, (i == 3));
        total++;
        if (exit_a !== 64'h0) begin $display("FAIL nomatch_exit actual=%h expected=0", exit_a); bad++; end
        // Bypass only works if the FIFO drained; address inside the tohost word still matches.
        beat(1, TOHOST + 64'h4, 1, 64'h9, 8'hFF, 1);
        total++;
        if (exit_a !== 64'h9) begin $display("FAIL nomatch_drained actual=%h expected=9", exit_a); bad++; end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) beat(1, TOHOST, 0, 0, 0, 0);
        total++;
        if (ovf_a !== 1'b0) begin $display("FAIL ovf_at_full actual=%b expected=0", ovf_a); bad++; end
        beat(1, TOHOST, 0, 0, 0, 0);
        total++;
        if (ovf_a !== 1'b1) begin $display("FAIL ovf_flag actual=%b expected=1", ovf_a); bad++; end
        total++;
        if (exit_a !== OVF_EXIT) begin $display("FAIL ovf_exit actual=%h expected=%h", exit_a, OVF_EXIT); bad++; end
        beat(0, 0, 1, 64'h1, 8'hFF, 1);
        total++;
        if (exit_a !== OVF_EXIT) begin $display("FAIL ovf_sticky actual=%h expected=%h", exit_a, OVF_EXIT); bad++; end
        rst_n = 0; #1;
        total++;
        if (ovf_a !== 1'b0 || exit_a !== 64'h0) begin
            $display("FAIL ovf_async_reset actual=%b/%h expected=0/0", ovf_a, exit_a); bad++;
        end
        @(posedge clk); #1 rst_n = 1;
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 4; i++) beat(1, OTHER, 0, 0, 0, 0);
        beat(1, TOHOST, 1, 64'h1, 8'hFF, 1);
        total++;
        if (ovf_a !== 1'b0) begin $display("FAIL pushpop_ovf actual=%b expected=0", ovf_a); bad++; end
        for (int i = 0; i < 3; i++) beat(0, 0, 1, 64'h1, 8'hFF, 1);
        total++;
        if (exit_a !== 64'h0) begin $display("FAIL pushpop_nomatch actual=%h expected=0", exit_a); bad++; end
        beat(0, 0, 1, 64'h7, 8'hFF, 1);
        total++;
        if (exit_a !== 64'h7) begin $display("FAIL pushpop_tail actual=%h expected=7", exit_a); bad++; end
    endtask

    task automatic test_watchdog();
        do_reset();
        repeat (99) @(posedge clk);
        #1;
        total++;
        if (exit_w !== 64'h0) begin $display("FAIL wd_early actual=%h expected=0", exit_w); bad++; end
        @(posedge clk); #1;
        total++;
        if (exit_w !== TO_EXIT) begin $display("FAIL wd_fire actual=%h expected=%h", exit_w, TO_EXIT); bad++; end
        total++;
        if (exit_a !== 64'h0) begin $display("FAIL wd_disabled actual=%h expected=0", exit_a); bad++; end
        repeat (5) @(posedge clk);
        #1 rst_n = 0; #1;
        total++;
        if (exit_w !== 64'h0) begin $display("FAIL wd_async_reset actual=%h expected=0", exit_w); bad++; end
        @(posedge clk); #1 rst_n = 1;
        repeat (99) @(posedge clk);
        #1;
        total++;
        if (exit_w !== 64'h0) begin $display("FAIL wd_restart_early actual=%h expected=0", exit_w); bad++; end
        @(posedge clk); #1;
        total++;
        if (exit_w !== TO_EXIT) begin $display("FAIL wd_restart_fire actual=%h expected=%h", exit_w, TO_EXIT); bad++; end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_w_before_aw();
        test_partial_strobes();
        test_burst_first_only();
        test_nonmatching();
        test_overflow();
        test_full_push_pop();
        test_watchdog();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
